msi_l1_cache: RTL

//  Private direct-mapped L1 data cache, downstream of each processor core. Accepts the core's per-cycle

---
 rtl/msi_l1_cache.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/msi_l1_cache.sv
// rtl/msi_l1_cache.sv - direct-mapped MSI-snooping L1 data cache, single-word lines
// Optional hit/miss counters enabled by defining L1_STATS_EN.
module msi_l1_cache #(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_op,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_flush,
`ifdef L1_STATS_EN
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses,
`endif
    output logic [DATA_W-1:0] snoop_data
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RDX  = 2'b10;
    localparam logic [1:0] OP_WB   = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_GNT, ST_WB, ST_FILL} fsm_t;
    typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

    fsm_t              state_q, state_d;
    line_t             st_q   [NUM_LINES];
    logic [TAG_W-1:0]  tag_q  [NUM_LINES];
    logic [DATA_W-1:0] data_q [NUM_LINES];

    logic [IDX_W-1:0] cpu_idx, snp_idx;
    logic [TAG_W-1:0] cpu_tag, snp_tag;
    logic             cpu_req, tag_hit, perm_hit, hit_ok, victim_dirty;
    logic             snp_hit, snp_block;
    line_t            cur_st, snp_st;

    assign cpu_idx = cpu_addr[IDX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W];
    assign snp_idx = snoop_addr[IDX_W-1:0];
    assign snp_tag = snoop_addr[ADDR_W-1:IDX_W];
    assign cpu_req = cpu_read | cpu_write;

    assign cur_st       = st_q[cpu_idx];
    assign tag_hit      = (cur_st != LN_I) && (tag_q[cpu_idx] == cpu_tag);
    assign perm_hit     = tag_hit && (!cpu_write || cur_st == LN_M);
    assign victim_dirty = (cur_st == LN_M) && (tag_q[cpu_idx] != cpu_tag);

    // Only BusRd/BusRdX hitting a valid line can change its state or force a flush.
    assign snp_st    = st_q[snp_idx];
    assign snp_hit   = snoop_valid && (snp_st != LN_I) && (tag_q[snp_idx] == snp_tag)
                       && (snoop_op == OP_RD || snoop_op == OP_RDX);
    assign snp_block = snp_hit && (snp_idx == cpu_idx);
    assign hit_ok    = (state_q == ST_IDLE) && cpu_req && perm_hit && !snp_block;

    assign snoop_flush = snp_hit && (snp_st == LN_M);
    assign snoop_data  = snoop_flush ? data_q[snp_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cpu_ready = hit_ok;
        cpu_rdata = hit_ok ? data_q[cpu_idx] : '0;
        bus_req   = 1'b0;
        bus_op    = OP_NONE;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && !perm_hit) state_d = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                bus_req = 1'b1;
                // Victim checked at grant time: a snoop may have cleaned it while waiting.
                if (bus_gnt) state_d = victim_dirty ? ST_WB : ST_FILL;
            end
            ST_WB: begin
                bus_req   = 1'b1;
                bus_op    = OP_WB;
                bus_addr  = {tag_q[cpu_idx], cpu_idx};
                bus_wdata = data_q[cpu_idx];
                if (bus_ack) state_d = ST_FILL;
            end
            ST_FILL: begin
                bus_req  = 1'b1;
                bus_op   = cpu_write ? OP_RDX : OP_RD;
                bus_addr = cpu_addr;
                if (bus_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                st_q[i]   <= LN_I;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (snp_hit) begin
                if (snoop_op == OP_RDX)    st_q[snp_idx] <= LN_I;
                else if (snp_st == LN_M)   st_q[snp_idx] <= LN_S;
            end
            if (hit_ok && cpu_write) data_q[cpu_idx] <= cpu_wdata;
            if (state_q == ST_WB && bus_ack) st_q[cpu_idx] <= LN_I;
            if (state_q == ST_FILL && bus_ack) begin
                tag_q[cpu_idx]  <= cpu_tag;
                data_q[cpu_idx] <= bus_rdata;
                st_q[cpu_idx]   <= cpu_write ? LN_M : LN_S;
            end
        end
    end

`ifdef L1_STATS_EN
    logic missed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_q    <= 1'b0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            // The retry hit after a fill belongs to the miss, not to the hit count.
            if (state_q == ST_IDLE && state_d == ST_WAIT_GNT) begin
                missed_q <= 1'b1;
                if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
            end
            if (cpu_ready) begin
                missed_q <= 1'b0;
                if (!missed_q && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
            end
        end
    end
`endif

endmodule
